imem_loader: RTL

- Fills the instruction memory that the fetch unit reads, from a byte stream delivered by a UART/debug front-end.
- Assembles bytes into big-endian 32-bit words, so the first byte received for a word becomes the byte at the lowest address. This matches the fetch unit's byte-wise read of `{im[a], im[a+1], im[a+2], im[a+3]}`.
- Drives the memory write port and holds the CPU in reset until a complete, checksum-verified image is loaded.

---
 rtl/imem_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: frames a byte stream (length, big-endian payload, XOR checksum)
// into 32-bit words on the imem write port and releases the CPU once the image verifies.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic [15:0] words_loaded,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t      r_state;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word;
  logic [7:0]  r_csum;
  logic        r_in_ready;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic [15:0] r_words_loaded;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic [15:0] w_len;
  logic [31:0] w_word;
  logic        w_last_word;

  assign w_accept    = in_valid & r_in_ready;
  assign w_len       = {r_len_hi, in_data};
  // First byte of a word ends up in [31:24]: big-endian to match the fetch unit.
  assign w_word      = {r_word, in_data};
  assign w_last_word = (r_words_loaded + 16'd1) == r_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_LEN_HI;
      r_len_hi       <= '0;
      r_len          <= '0;
      r_byte_cnt     <= '0;
      r_word         <= '0;
      r_csum         <= '0;
      r_in_ready     <= 1'b1;
      r_we           <= 1'b0;
      r_waddr        <= BASE_ADDR;
      r_wdata        <= '0;
      r_words_loaded <= '0;
      r_cpu_hold     <= 1'b1;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the default below is overridden later in
      // the same block, which makes r_we a clean single-cycle strobe without extra logic.
      r_we <= 1'b0;
      case (r_state)
        S_LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= in_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len > MAX_N) begin
              r_state    <= S_ERR;
              r_error    <= 1'b1;
              r_in_ready <= 1'b0;
            end else if (w_len == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum     <= r_csum ^ in_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= w_word[23:0];
            if (r_byte_cnt == 2'd3) begin
              r_we           <= 1'b1;
              r_waddr        <= BASE_ADDR + 32'({r_words_loaded, 2'b00});
              r_wdata        <= w_word;
              r_words_loaded <= r_words_loaded + 16'd1;
              if (w_last_word) begin
                r_state <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            r_state        <= S_LEN_HI;
            r_in_ready     <= 1'b1;
            r_len_hi       <= '0;
            r_len          <= '0;
            r_byte_cnt     <= '0;
            r_word         <= '0;
            r_csum         <= '0;
            r_waddr        <= BASE_ADDR;
            r_words_loaded <= '0;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
          end
        end
        default: begin
          r_state <= S_LEN_HI;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign imem_we      = r_we;
  assign imem_waddr   = r_waddr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words_loaded;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign error        = r_error;

endmodule
